// File: rtl/alu_pkg.sv
// Shared opcode encodings and decode helpers for the integer ALU functional unit.
package alu_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LUI  = 4'd3;
  localparam logic [3:0] OP_ORI  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRAI = 4'd6;
  localparam logic [3:0] OP_LB   = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SB   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_SUB  = 4'd11;
  localparam logic [3:0] OP_AND  = 4'd12;
  localparam logic [3:0] OP_SLL  = 4'd13;
  localparam logic [3:0] OP_SRL  = 4'd14;
  localparam logic [3:0] OP_SLT  = 4'd15;

  // Loads and stores only need an effective address from this unit.
  function automatic logic is_mem_op(input logic [3:0] optype);
    return (optype >= OP_LB) && (optype <= OP_SW);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: decodes the optype and produces the result or effective address.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      optype,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic signed [XLEN-1:0] sra_res;
  logic                   slt_res;

  assign sra_res = $signed(src1) >>> imm[SHW-1:0];
  assign slt_res = $signed(src1) < $signed(src2);

  always_comb begin
    result = '0;
    if (is_mem_op(optype)) begin
      result = src1 + imm;
    end else begin
      case (optype)
        OP_ADD:  result = src1 + src2;
        OP_ADDI: result = src1 + imm;
        OP_LUI:  result = imm;
        OP_ORI:  result = src1 | imm;
        OP_XOR:  result = src1 ^ src2;
        OP_SRAI: result = sra_res;
        OP_SUB:  result = src1 - src2;
        OP_AND:  result = src1 & src2;
        OP_SLL:  result = src1 << src2[SHW-1:0];
        OP_SRL:  result = src1 >> src2[SHW-1:0];
        OP_SLT:  result = {{(XLEN-1){1'b0}}, slt_res};
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer ALU functional unit: elastic valid/ready stages between issue and the CDB,
// with flush of all in-flight ops.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned FU_ID_W = 2,
  parameter int unsigned FU_ID   = 0,
  parameter int unsigned STAGES  = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               issue_valid,
  input  logic [FU_ID_W-1:0] issue_fu_id,
  input  logic [3:0]         issue_optype,
  input  logic [XLEN-1:0]    issue_src1,
  input  logic [XLEN-1:0]    issue_src2,
  input  logic [XLEN-1:0]    issue_imm,
  input  logic [TAG_W-1:0]   issue_tag,
  output logic               issue_ready,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [XLEN-1:0]    wb_data,
  output logic [TAG_W-1:0]   wb_tag,
  output logic [3:0]         wb_optype,
  output logic [XLEN-1:0]    wb_store_data
);

  localparam logic [FU_ID_W-1:0] FuSel = FU_ID_W'(FU_ID);

  typedef struct packed {
    logic             valid;
    logic [3:0]       optype;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
    logic [XLEN-1:0]  store_data;
  } stage_t;

  stage_t            stage_q [STAGES];
  stage_t            issue_st;
  logic [STAGES:0]   move;
  logic [XLEN-1:0]   alu_result;
  logic              accept;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu_core (
    .optype (issue_optype),
    .src1   (issue_src1),
    .src2   (issue_src2),
    .imm    (issue_imm),
    .result (alu_result)
  );

  // move[i]: stage i may load this cycle; ripples back from the CDB ready.
  always_comb begin
    move         = '0;
    move[STAGES] = wb_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      move[i] = !stage_q[i].valid || move[i+1];
    end
  end

  assign issue_ready = move[0];
  assign accept      = issue_valid && issue_ready && (issue_fu_id == FuSel) && !flush;

  always_comb begin
    issue_st            = '0;
    issue_st.valid      = accept;
    issue_st.optype     = issue_optype;
    issue_st.tag        = issue_tag;
    issue_st.data       = alu_result;
    issue_st.store_data = issue_src2;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    stage_t st_in;
    stage_t st_q;

    if (g == 0) begin : g_head
      assign st_in = issue_st;
    end else begin : g_body
      assign st_in = stage_q[g-1];
    end

    // Payload only loads with a valid op so a stalled or idle stage keeps its last contents.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        st_q <= '0;
      end else if (flush) begin
        st_q.valid <= 1'b0;
      end else if (move[g]) begin
        if (st_in.valid) begin
          st_q <= st_in;
        end else begin
          st_q.valid <= 1'b0;
        end
      end
    end

    assign stage_q[g] = st_q;
  end

  assign wb_valid      = stage_q[STAGES-1].valid;
  assign wb_data       = stage_q[STAGES-1].data;
  assign wb_tag        = stage_q[STAGES-1].tag;
  assign wb_optype     = stage_q[STAGES-1].optype;
  assign wb_store_data = stage_q[STAGES-1].store_data;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: scoreboard of expected writebacks checked by a negedge monitor.
module tb_alu_pipe;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned FU_W   = 2;
  localparam int unsigned FU_ID  = 0;
  localparam int unsigned STAGES = 2;

  logic             clk;
  logic             rstn;
  logic             flush;
  logic             issue_valid;
  logic [FU_W-1:0]  issue_fu_id;
  logic [3:0]       issue_optype;
  logic [XLEN-1:0]  issue_src1;
  logic [XLEN-1:0]  issue_src2;
  logic [XLEN-1:0]  issue_imm;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_ready;
  logic             wb_valid;
  logic             wb_ready;
  logic [XLEN-1:0]  wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic [3:0]       wb_optype;
  logic [XLEN-1:0]  wb_store_data;

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    logic [3:0]       op;
    logic [XLEN-1:0]  st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_pipe #(
    .XLEN    (XLEN),
    .TAG_W   (TAG_W),
    .FU_ID_W (FU_W),
    .FU_ID   (FU_ID),
    .STAGES  (STAGES)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_fu_id   (issue_fu_id),
    .issue_optype  (issue_optype),
    .issue_src1    (issue_src1),
    .issue_src2    (issue_src2),
    .issue_imm     (issue_imm),
    .issue_tag     (issue_tag),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_data       (wb_data),
    .wb_tag        (wb_tag),
    .wb_optype     (wb_optype),
    .wb_store_data (wb_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake seen at the negedge completes at the following rising edge.
  always @(negedge clk) begin
    if (rstn && wb_valid) begin
      if (wb_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_wb", 32'(wb_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wb_data", wb_data, e.data);
          check("wb_tag", 32'(wb_tag), 32'(e.tag));
          check("wb_optype", 32'(wb_optype), 32'(e.op));
          check("wb_store_data", wb_store_data, e.st);
        end
      end else if (sb.size() != 0) begin
        check("stall_data", wb_data, sb[0].data);
        check("stall_tag", 32'(wb_tag), 32'(sb[0].tag));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that samples the issue.
  task automatic issue(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] imm, input logic [5:0] tag, input logic [1:0] fu,
                       input bit exp_ready, input bit exp_acc, input logic [31:0] res);
    exp_t e;
    issue_valid  = 1'b1;
    issue_optype = op;
    issue_src1   = s1;
    issue_src2   = s2;
    issue_imm    = imm;
    issue_tag    = tag;
    issue_fu_id  = fu;
    @(negedge clk);
    check("issue_ready", 32'(issue_ready), 32'(exp_ready));
    if (exp_acc) begin
      e.data = res;
      e.tag  = tag;
      e.op   = op;
      e.st   = s2;
      sb.push_back(e);
    end
    cyc();
    issue_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    cyc();
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check(tag, 32'(wb_valid), 32'd0);
    cyc();
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; wb_ready = 1'b1; issue_valid = 1'b0;
    issue_fu_id = '0; issue_optype = '0; issue_src1 = '0; issue_src2 = '0;
    issue_imm = '0; issue_tag = '0;

    // Reset state
    cyc(); cyc();
    @(negedge clk);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_tag", 32'(wb_tag), 32'd0);
    check("rst_wb_optype", 32'(wb_optype), 32'd0);
    check("rst_wb_store", wb_store_data, 32'd0);
    cyc();
    rstn = 1'b1;
    @(negedge clk);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    cyc();

    // Latency: visible one cycle after the accept edge
    issue(4'd1, 32'd5, 32'd7, 32'd0, 6'd3, 2'd0, 1, 1, 32'd12);
    expect_idle("lat_not_yet");
    @(negedge clk);
    check("lat_valid", 32'(wb_valid), 32'd1);
    cyc();

    // Back-to-back throughput
    issue(4'd11, 32'd3, 32'd5, 32'd0, 6'd4, 2'd0, 1, 1, 32'hFFFF_FFFE);
    issue(4'd6, 32'h8000_0000, 32'd0, 32'd4, 6'd5, 2'd0, 1, 1, 32'hF800_0000);
    issue(4'd15, 32'hFFFF_FFFF, 32'd0, 32'd0, 6'd6, 2'd0, 1, 1, 32'd1);
    issue(4'd3, 32'd0, 32'd0, 32'h1234_5000, 6'd7, 2'd0, 1, 1, 32'h1234_5000);
    @(negedge clk);
    check("b2b_valid_a", 32'(wb_valid), 32'd1);
    cyc();
    @(negedge clk);
    check("b2b_valid_b", 32'(wb_valid), 32'd1);
    cyc();
    expect_idle("b2b_idle");

    // Backpressure: pipe fills after two ops, third is refused
    wb_ready = 1'b0;
    issue(4'd12, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0, 6'd8, 2'd0, 1, 1, 32'h0F00_0F00);
    issue(4'd13, 32'd1, 32'h25, 32'd0, 6'd9, 2'd0, 1, 1, 32'h20);
    issue(4'd14, 32'h8000_0000, 32'd31, 32'd0, 6'd10, 2'd0, 0, 0, 32'd1);
    cyc(); cyc();
    @(negedge clk);
    check("stall_ready_low", 32'(issue_ready), 32'd0);
    cyc();
    wb_ready = 1'b1;
    wait_drain();

    // Wrong FU select is ignored
    issue(4'd1, 32'd9, 32'd9, 32'd0, 6'd11, 2'd1, 1, 0, 32'd18);
    expect_idle("fu_ignored_a");
    expect_idle("fu_ignored_b");

    // Memory address, store data and remaining codes
    issue(4'd10, 32'h100, 32'hAB, 32'd8, 6'd12, 2'd0, 1, 1, 32'h108);
    issue(4'd2, 32'd10, 32'd0, 32'hFFFF_FFFF, 6'd13, 2'd0, 1, 1, 32'd9);
    issue(4'd4, 32'hF0, 32'd0, 32'h0F, 6'd14, 2'd0, 1, 1, 32'hFF);
    issue(4'd5, 32'hA5A5, 32'hFFFF, 32'd0, 6'd15, 2'd0, 1, 1, 32'h5A5A);
    issue(4'd8, 32'h200, 32'd0, 32'd4, 6'd16, 2'd0, 1, 1, 32'h204);
    issue(4'd9, 32'h300, 32'h55, 32'hFFFF_FFFC, 6'd17, 2'd0, 1, 1, 32'h2FC);
    issue(4'd0, 32'd5, 32'd6, 32'd7, 6'd18, 2'd0, 1, 1, 32'd0);
    issue(4'd15, 32'd5, 32'hFFFF_FFFD, 32'd0, 6'd19, 2'd0, 1, 1, 32'd0);
    issue(4'd14, 32'h8000_0000, 32'h3F, 32'd0, 6'd20, 2'd0, 1, 1, 32'd1);
    issue(4'd7, 32'h1000, 32'd0, 32'hFFFF_FFFF, 6'd21, 2'd0, 1, 1, 32'hFFF);
    wait_drain();

    // Flush with two in flight and a new issue in the flush cycle
    issue(4'd1, 32'd1, 32'd1, 32'd0, 6'd22, 2'd0, 1, 1, 32'd2);
    issue(4'd1, 32'd2, 32'd2, 32'd0, 6'd23, 2'd0, 1, 1, 32'd4);
    flush = 1'b1;
    issue(4'd1, 32'd3, 32'd3, 32'd0, 6'd24, 2'd0, 1, 0, 32'd6);
    flush = 1'b0;
    sb.delete();
    expect_idle("flush_idle_a");
    expect_idle("flush_idle_b");
    expect_idle("flush_idle_c");

    // Reset while stalled with a full pipe
    wb_ready = 1'b0;
    issue(4'd12, 32'hFFFF_FFFF, 32'h1234, 32'd0, 6'd25, 2'd0, 1, 1, 32'h1234);
    issue(4'd5, 32'hF, 32'hF0, 32'd0, 6'd26, 2'd0, 1, 1, 32'hFF);
    cyc();
    rstn = 1'b0;
    cyc();
    @(negedge clk);
    check("rst2_wb_valid", 32'(wb_valid), 32'd0);
    check("rst2_wb_data", wb_data, 32'd0);
    check("rst2_wb_tag", 32'(wb_tag), 32'd0);
    check("rst2_wb_optype", 32'(wb_optype), 32'd0);
    check("rst2_wb_store", wb_store_data, 32'd0);
    cyc();
    rstn = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst2_issue_ready", 32'(issue_ready), 32'd1);
    cyc();
    wb_ready = 1'b1;
    issue(4'd2, 32'd40, 32'd0, 32'd2, 6'd27, 2'd0, 1, 1, 32'd42);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
